// File: rtl/best_arr_sender.sv
// Output-side result streamer: reads best index/distance memories in column-blocked
// order and pushes indices, then split distances, into the output FIFO.
module best_arr_sender #(
    parameter int DATA_WIDTH = 11,
    parameter int ROW_SIZE   = 26,
    parameter int COL_SIZE   = 19,
    parameter int BLOCKING   = 4,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
    input  logic                    io_clk,
    input  logic                    io_rst_n,
    input  logic                    send_best_arr,
    output logic                    send_done,
    output logic                    busy,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]   mem_idx_rdata,
    input  logic [2*DATA_WIDTH-1:0] mem_dist_rdata,
    output logic                    out_fifo_wenq,
    output logic [DATA_WIDTH-1:0]   out_fifo_wdata,
    input  logic                    out_fifo_wfull_n
);

    localparam int HALF = ROW_SIZE / 2;
    localparam int XIW  = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;
    localparam int YW   = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;

    localparam logic [ADDR_WIDTH-1:0] HALF_A  = ADDR_WIDTH'(HALF);
    localparam logic [ADDR_WIDTH-1:0] BLK_A   = ADDR_WIDTH'(BLOCKING);
    localparam logic [ADDR_WIDTH-1:0] ROW_A   = ADDR_WIDTH'(ROW_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_A  = ADDR_WIDTH'(1'b0);
    localparam logic [XIW-1:0]        XI_LAST = XIW'(BLOCKING - 1);
    localparam logic [XIW-1:0]        XI_ONE  = XIW'(1'b1);
    localparam logic [XIW-1:0]        XI_ZERO = XIW'(1'b0);
    localparam logic [YW-1:0]         Y_LAST  = YW'(COL_SIZE - 1);
    localparam logic [YW-1:0]         Y_ONE   = YW'(1'b1);
    localparam logic [YW-1:0]         Y_ZERO  = YW'(1'b0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_CAP   = 3'd2,
        S_PUSH0 = 3'd3,
        S_PUSH1 = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    phase_q, phase_d;      // 0: index sweep, 1: distance sweep
    logic                    px_q, px_d;
    logic [XIW-1:0]          xi_q, xi_d;
    logic [YW-1:0]           y_q, y_d;
    logic [ADDR_WIDTH-1:0]   xb_q, xb_d;            // x*BLOCKING within the half row
    logic [ADDR_WIDTH-1:0]   col_base_q, col_base_d;
    logic [ADDR_WIDTH-1:0]   row_off_q, row_off_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rd_en_q, rd_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   dist_hi_q, dist_hi_d;
    logic                    wenq_s;
    logic                    advance_s;
    logic                    xi_wrap_s;
    logic                    x_wrap_s;

    // xi wraps early on the ragged last block so skipped columns cost nothing
    assign xi_wrap_s = (xi_q == XI_LAST) ||
                       ((xb_q + ADDR_WIDTH'(xi_q) + ONE_A) >= HALF_A);
    assign x_wrap_s  = ((xb_q + BLK_A) >= HALF_A);

    // Next-state, counter stepping and FIFO handshake
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        px_d       = px_q;
        xi_d       = xi_q;
        y_d        = y_q;
        xb_d       = xb_q;
        col_base_d = col_base_q;
        row_off_d  = row_off_q;
        done_d     = done_q;
        wdata_d    = wdata_q;
        dist_hi_d  = dist_hi_q;
        wenq_s     = 1'b0;
        advance_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (send_best_arr) begin
                    state_d    = S_RD;
                    done_d     = 1'b0;
                    phase_d    = 1'b0;
                    px_d       = 1'b0;
                    xi_d       = XI_ZERO;
                    y_d        = Y_ZERO;
                    xb_d       = ZERO_A;
                    col_base_d = ZERO_A;
                    row_off_d  = ZERO_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                wdata_d   = phase_q ? mem_dist_rdata[DATA_WIDTH-1:0] : mem_idx_rdata;
                dist_hi_d = mem_dist_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
                state_d   = S_PUSH0;
            end
            S_PUSH0: begin
                if (out_fifo_wfull_n) begin
                    wenq_s = 1'b1;
                    if (phase_q) begin
                        state_d = S_PUSH1;
                        wdata_d = dist_hi_q;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    state_d = S_PUSH0;
                end
            end
            S_PUSH1: begin
                if (out_fifo_wfull_n) begin
                    wenq_s    = 1'b1;
                    advance_s = 1'b1;
                end else begin
                    state_d = S_PUSH1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Nested loop step: xi, then y, then x block, then half, then phase
        if (advance_s) begin
            if (!xi_wrap_s) begin
                xi_d    = xi_q + XI_ONE;
                state_d = S_RD;
            end else begin
                xi_d = XI_ZERO;
                if (y_q != Y_LAST) begin
                    y_d       = y_q + Y_ONE;
                    row_off_d = row_off_q + ROW_A;
                    state_d   = S_RD;
                end else begin
                    y_d       = Y_ZERO;
                    row_off_d = ZERO_A;
                    if (!x_wrap_s) begin
                        xb_d       = xb_q + BLK_A;
                        col_base_d = col_base_q + BLK_A;
                        state_d    = S_RD;
                    end else begin
                        xb_d = ZERO_A;
                        if (!px_q) begin
                            px_d       = 1'b1;
                            col_base_d = HALF_A;
                            state_d    = S_RD;
                        end else begin
                            px_d       = 1'b0;
                            col_base_d = ZERO_A;
                            if (!phase_q) begin
                                phase_d = 1'b1;
                                state_d = S_RD;
                            end else begin
                                state_d = S_FIN;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
        end else begin
            advance_s = 1'b0;
        end
    end

    // Registered versions of the read strobe, address and busy flag
    always_comb begin
        rd_en_d = (state_d == S_RD);
        busy_d  = (state_d == S_RD) || (state_d == S_CAP) ||
                  (state_d == S_PUSH0) || (state_d == S_PUSH1);
        addr_d  = col_base_d + row_off_d + ADDR_WIDTH'(xi_d);
    end

    // State and datapath registers
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            px_q       <= 1'b0;
            xi_q       <= XI_ZERO;
            y_q        <= Y_ZERO;
            xb_q       <= ZERO_A;
            col_base_q <= ZERO_A;
            row_off_q  <= ZERO_A;
            addr_q     <= ZERO_A;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wdata_q    <= {DATA_WIDTH{1'b0}};
            dist_hi_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            px_q       <= px_d;
            xi_q       <= xi_d;
            y_q        <= y_d;
            xb_q       <= xb_d;
            col_base_q <= col_base_d;
            row_off_q  <= row_off_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wdata_q    <= wdata_d;
            dist_hi_q  <= dist_hi_d;
        end
    end

    assign send_done      = done_q;
    assign busy           = busy_q;
    assign mem_rd_en      = rd_en_q;
    assign mem_rd_addr    = addr_q;
    assign out_fifo_wenq  = wenq_s;
    assign out_fifo_wdata = wdata_q;

endmodule

// File: tb/tb_best_arr_sender.sv
// Randomized self-checking bench for best_arr_sender against a loop-order reference model.
module tb_best_arr_sender;

    localparam int DW   = 11;
    localparam int ROW  = 26;
    localparam int COL  = 19;
    localparam int BLK  = 4;
    localparam int NQ   = ROW * COL;
    localparam int AW   = $clog2(NQ);
    localparam int H    = ROW / 2;
    localparam int NX   = (H + BLK - 1) / BLK;

    logic            clk;
    logic            io_rst_n;
    logic            send_best_arr;
    logic            send_done;
    logic            busy;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_rd_addr;
    logic [DW-1:0]   mem_idx_rdata;
    logic [2*DW-1:0] mem_dist_rdata;
    logic            out_fifo_wenq;
    logic [DW-1:0]   out_fifo_wdata;
    logic            out_fifo_wfull_n;

    logic [DW-1:0]   idx_mem  [0:511];
    logic [2*DW-1:0] dist_mem [0:511];
    logic [DW-1:0]   got_q [$];
    logic [DW-1:0]   exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    best_arr_sender #(
        .DATA_WIDTH (DW),
        .ROW_SIZE   (ROW),
        .COL_SIZE   (COL),
        .BLOCKING   (BLK)
    ) dut (
        .io_clk           (clk),
        .io_rst_n         (io_rst_n),
        .send_best_arr    (send_best_arr),
        .send_done        (send_done),
        .busy             (busy),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_idx_rdata    (mem_idx_rdata),
        .mem_dist_rdata   (mem_dist_rdata),
        .out_fifo_wenq    (out_fifo_wenq),
        .out_fifo_wdata   (out_fifo_wdata),
        .out_fifo_wfull_n (out_fifo_wfull_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    // Memory model: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_idx_rdata  <= idx_mem[mem_rd_addr];
            mem_dist_rdata <= dist_mem[mem_rd_addr];
        end
    end

    // FIFO-side monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (io_rst_n) begin
            if (!out_fifo_wfull_n) check_eq("wenq_while_full", {31'd0, out_fifo_wenq}, 32'd0);
            if (out_fifo_wenq) got_q.push_back(out_fifo_wdata);
        end
    end

    // Reference: the host's sweep order written as plain nested loops
    task automatic build_exp();
        int ord[$];
        exp_q.delete();
        for (int px = 0; px < 2; px++)
            for (int x = 0; x < NX; x++)
                for (int y = 0; y < COL; y++)
                    for (int xi = 0; xi < BLK; xi++)
                        if (x * BLK + xi < H) ord.push_back(px * H + y * ROW + x * BLK + xi);
        foreach (ord[i]) exp_q.push_back(idx_mem[ord[i]]);
        foreach (ord[i]) begin
            exp_q.push_back(dist_mem[ord[i]][DW-1:0]);
            exp_q.push_back(dist_mem[ord[i]][2*DW-1:DW]);
        end
    endtask

    task automatic fill_mem(input bit identity);
        for (int a = 0; a < 512; a++) begin
            if (identity) begin
                idx_mem[a]  = DW'(a);
                dist_mem[a] = (2*DW)'(a * 2049 + 5);
            end else begin
                idx_mem[a]  = DW'($urandom_range(0, 2047));
                dist_mem[a] = (2*DW)'($urandom_range(0, 4194303));
            end
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        send_best_arr = 1'b1;
        @(posedge clk); #1;
        send_best_arr = 1'b0;
    endtask

    task automatic compare_stream();
        check_eq("word_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("word%0d", i), {21'd0, got_q[i]}, {21'd0, exp_q[i]});
    endtask

    // k counts falling edges after the edge that samples the start
    task automatic run_stream(input bit timing, input bit bp7, input bit bp_rand,
                              input int poke_k, input int rst_k);
        int k;
        int bp_start;
        bit done;
        k = 0;
        bp_start = -100;
        done = 1'b0;
        got_q.delete();
        do_start();
        while (!done) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check_eq("busy_rise", {31'd0, busy}, 32'd1);
                check_eq("rd_en_first", {31'd0, mem_rd_en}, 32'd1);
                check_eq("rd_addr_first", {23'd0, mem_rd_addr}, 32'd0);
                check_eq("done_cleared", {31'd0, send_done}, 32'd0);
            end
            if (bp7 && k >= bp_start + 2 && k <= bp_start + 11) begin
                check_eq("bp_hold_data", {21'd0, out_fifo_wdata}, {21'd0, exp_q[7]});
                check_eq("bp_no_push", got_q.size(), 7);
            end
            if (timing) begin
                if (k == 3) check_eq("first_push", {31'd0, out_fifo_wenq}, 32'd1);
                if (k == 3458) check_eq("done_early", {31'd0, send_done}, 32'd0);
                if (k == 3459) begin
                    check_eq("done_time", {31'd0, send_done}, 32'd1);
                    check_eq("busy_fin", {31'd0, busy}, 32'd0);
                end
                if (k == 3460) begin
                    check_eq("fin_start_ignored", {31'd0, busy}, 32'd0);
                    check_eq("done_sticky", {31'd0, send_done}, 32'd1);
                end
                if (k == 3461) done = 1'b1;
            end else if (k > 1 && send_done) begin
                done = 1'b1;
            end
            if (k > 20000) begin
                check_eq("run_timeout", {31'd0, send_done}, 32'd1);
                done = 1'b1;
            end
            @(posedge clk); #1;
            send_best_arr = (k == poke_k);
            if (k == rst_k) begin
                io_rst_n = 1'b0;
                #1;
                check_eq("rst_send_done", {31'd0, send_done}, 32'd0);
                check_eq("rst_busy", {31'd0, busy}, 32'd0);
                check_eq("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
                check_eq("rst_rd_addr", {23'd0, mem_rd_addr}, 32'd0);
                check_eq("rst_wenq", {31'd0, out_fifo_wenq}, 32'd0);
                check_eq("rst_wdata", {21'd0, out_fifo_wdata}, 32'd0);
                done = 1'b1;
            end
            if (bp7 && bp_start < 0 && got_q.size() == 7) bp_start = k + 1;
            if (bp7 && k + 1 >= bp_start && k + 1 <= bp_start + 11)
                out_fifo_wfull_n = 1'b0;
            else if (bp_rand && k > 300)
                out_fifo_wfull_n = ($urandom_range(0, 3) != 0);
            else
                out_fifo_wfull_n = 1'b1;
        end
        out_fifo_wfull_n = 1'b1;
        send_best_arr = 1'b0;
    endtask

    initial begin
        io_rst_n         = 1'b0;
        send_best_arr    = 1'b0;
        out_fifo_wfull_n = 1'b1;
        fill_mem(1'b1);
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_send_done", {31'd0, send_done}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check_eq("reset_rd_addr", {23'd0, mem_rd_addr}, 32'd0);
        check_eq("reset_wenq", {31'd0, out_fifo_wenq}, 32'd0);
        check_eq("reset_wdata", {21'd0, out_fifo_wdata}, 32'd0);
        io_rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Identity memories, exact timing, start during FIN
        build_exp();
        run_stream(1'b1, 1'b0, 1'b0, 3458, -1);
        compare_stream();
        if (got_q.size() >= 498) begin
            check_eq("w0", got_q[0], 0);
            check_eq("w3", got_q[3], 3);
            check_eq("w4", got_q[4], 26);
            check_eq("w75", got_q[75], 471);
            check_eq("w76", got_q[76], 4);
            check_eq("w228", got_q[228], 12);
            check_eq("w246", got_q[246], 480);
            check_eq("w247", got_q[247], 13);
            check_eq("w493", got_q[493], 493);
            check_eq("w494", got_q[494], 5);
            check_eq("w495", got_q[495], 0);
            check_eq("w496", got_q[496], 6);
            check_eq("w497", got_q[497], 1);
        end

        // Random memories, stall at query 7, start while busy, random backpressure
        fill_mem(1'b0);
        build_exp();
        run_stream(1'b0, 1'b1, 1'b1, 99, -1);
        compare_stream();

        // Re-run on the same contents
        check_eq("done_before_rerun", {31'd0, send_done}, 32'd1);
        run_stream(1'b0, 1'b0, 1'b0, -1, -1);
        compare_stream();

        // Reset during the distance sweep, then restart from scratch
        run_stream(1'b0, 1'b0, 1'b0, -1, 2000);
        repeat (3) @(posedge clk);
        #1;
        io_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("post_rst_idle", {31'd0, busy}, 32'd0);
        fill_mem(1'b1);
        build_exp();
        run_stream(1'b0, 1'b0, 1'b0, -1, -1);
        compare_stream();
        if (got_q.size() > 0) check_eq("restart_word0", got_q[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
